// File: rtl/triangle_feeder.sv
// Triangle feeder: reads a count and then six coordinate words per triangle from the command stream, and answers each Rasteriser next_triangle request with registered, clamped vertices.
// data_ready rises 6 cycles after a request when the stream never stalls; a low word_valid just stalls the fetch.
module triangle_feeder #(
  parameter int COORD_W  = 16,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               opcode_received,
  input  logic [COORD_W-1:0] word_in,
  input  logic               word_valid,
  output logic               word_ready,
  input  logic               next_triangle,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] x2,
  output logic [COORD_W-1:0] y2,
  output logic [COORD_W-1:0] x3,
  output logic [COORD_W-1:0] y3,
  output logic               data_ready,
  output logic               triangle_done,
  output logic               frame_ready,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE, GET_COUNT, WAIT_REQ, FETCH, READY, DONE
  } state_t;

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - 1);

  state_t             state;
  logic [COORD_W-1:0] remaining;
  logic [2:0]         idx;
  logic [COORD_W-1:0] shadow [6];
  logic [COORD_W-1:0] clamped;
  logic               xfer;

  assign word_ready = (state == GET_COUNT) || (state == FETCH);
  assign busy       = (state != IDLE);
  assign xfer       = word_valid && word_ready;

  // Odd slots carry y, even slots carry x.
  always_comb begin
    clamped = word_in;
    if (idx[0]) begin
      if (word_in > Y_MAX) clamped = Y_MAX;
    end else begin
      if (word_in > X_MAX) clamped = X_MAX;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      remaining     <= '0;
      idx           <= '0;
      x1            <= '0;
      y1            <= '0;
      x2            <= '0;
      y2            <= '0;
      x3            <= '0;
      y3            <= '0;
      data_ready    <= 1'b0;
      triangle_done <= 1'b0;
      frame_ready   <= 1'b0;
      for (int i = 0; i < 6; i++) shadow[i] <= '0;
    end else begin
      triangle_done <= 1'b0;
      frame_ready   <= 1'b0;
      case (state)
        IDLE: begin
          if (opcode_received) state <= GET_COUNT;
        end
        GET_COUNT: begin
          if (xfer) begin
            remaining <= word_in;
            if (word_in == '0) begin
              state         <= DONE;
              triangle_done <= 1'b1;
              frame_ready   <= 1'b1;
            end else begin
              state <= WAIT_REQ;
            end
          end
        end
        WAIT_REQ: begin
          if (next_triangle) begin
            idx   <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (xfer) begin
            shadow[idx] <= clamped;
            idx         <= idx + 3'd1;
            // Last slot: publish all six at once so outputs never show a partial triangle.
            if (idx == 3'd5) begin
              x1         <= shadow[0];
              y1         <= shadow[1];
              x2         <= shadow[2];
              y2         <= shadow[3];
              x3         <= shadow[4];
              y3         <= clamped;
              remaining  <= remaining - 1'b1;
              data_ready <= 1'b1;
              state      <= READY;
            end
          end
        end
        READY: begin
          if (next_triangle) begin
            data_ready <= 1'b0;
            if (remaining == '0) begin
              state         <= DONE;
              triangle_done <= 1'b1;
              frame_ready   <= 1'b1;
            end else begin
              idx   <= '0;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_feeder.sv
// Bench for triangle_feeder: directed scenarios plus randomized triangle lists, checked against an expected-vertex model.
module tb_triangle_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        opcode_received;
  logic [15:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        next_triangle;
  logic [15:0] x1, y1, x2, y2, x3, y3;
  logic        data_ready, triangle_done, frame_ready, busy;

  triangle_feeder dut (
    .clk(clk), .reset(reset), .opcode_received(opcode_received),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .next_triangle(next_triangle),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
    .data_ready(data_ready), .triangle_done(triangle_done),
    .frame_ready(frame_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_coord [6];
  logic [15:0] cur_w [6];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] clamp(input logic [15:0] v, input int slot);
    int unsigned lim;
    lim = (slot % 2 == 1) ? 479 : 639;
    return (v > lim) ? 16'(lim) : v;
  endfunction

  task automatic check_coords(input string tag);
    check({tag, "_x1"}, x1, exp_coord[0]);
    check({tag, "_y1"}, y1, exp_coord[1]);
    check({tag, "_x2"}, x2, exp_coord[2]);
    check({tag, "_y2"}, y2, exp_coord[3]);
    check({tag, "_x3"}, x3, exp_coord[4]);
    check({tag, "_y3"}, y3, exp_coord[5]);
  endtask

  task automatic start_list(input logic [15:0] count);
    @(negedge clk) opcode_received = 1'b1;
    @(negedge clk) opcode_received = 1'b0;
    check("get_count_rdy", word_ready, 1);
    word_valid = 1'b1;
    word_in    = count;
    @(negedge clk) word_valid = 1'b0;
    if (count == 0) begin
      check("zero_done", triangle_done, 1);
      check("zero_frame", frame_ready, 1);
      check("zero_dr", data_ready, 0);
      @(negedge clk);
      check("zero_done_end", triangle_done, 0);
      check("zero_idle", busy, 0);
    end else begin
      check("wait_req_busy", busy, 1);
      check("wait_req_rdy", word_ready, 0);
    end
  endtask

  // stall: 0 none, 1 alternate valid, 2 random; poke injects ignored opcode/next mid-fetch
  task automatic deliver(input int stall, input bit poke);
    int sent = 0;
    int cyc = 0;
    bit poked = 0;
    @(negedge clk) next_triangle = 1'b1;
    @(negedge clk) next_triangle = 1'b0;
    while (sent < 6 && cyc < 200) begin
      opcode_received = 1'b0;
      next_triangle   = 1'b0;
      check("fetch_dr", data_ready, 0);
      check("fetch_rdy", word_ready, 1);
      check("fetch_hold_x1", x1, exp_coord[0]);
      check("fetch_hold_y3", y3, exp_coord[5]);
      if (poke && sent == 2 && !poked) begin
        poked = 1;
        opcode_received = 1'b1;
        next_triangle   = 1'b1;
        word_valid      = 1'b0;
      end else if ((stall == 1 && cyc % 2 == 1) || (stall == 2 && $urandom_range(0, 1) == 1)) begin
        word_valid = 1'b0;
      end else begin
        word_valid = 1'b1;
        word_in    = cur_w[sent];
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    opcode_received = 1'b0;
    next_triangle   = 1'b0;
    word_valid      = 1'b0;
    check("fetch_timeout", (cyc < 200) ? 1 : 0, 1);
    for (int i = 0; i < 6; i++) exp_coord[i] = clamp(cur_w[i], i);
    check("data_ready", data_ready, 1);
    if (stall == 0 && !poke) check("latency", cyc, 6);
    check_coords("tri");
    @(negedge clk);
    check("ready_hold", data_ready, 1);
  endtask

  task automatic finish_list();
    @(negedge clk) next_triangle = 1'b1;
    @(negedge clk) next_triangle = 1'b0;
    check("done", triangle_done, 1);
    check("frame", frame_ready, 1);
    check("done_dr", data_ready, 0);
    check_coords("done_hold");
    @(negedge clk);
    check("done_pulse_end", triangle_done, 0);
    check("frame_pulse_end", frame_ready, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic set_words(input int a, input int b, input int c,
                           input int d, input int e, input int f);
    cur_w[0] = 16'(a); cur_w[1] = 16'(b); cur_w[2] = 16'(c);
    cur_w[3] = 16'(d); cur_w[4] = 16'(e); cur_w[5] = 16'(f);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 3))
        0:       cur_w[i] = 16'($urandom_range(0, 65535));
        1:       cur_w[i] = (i % 2 == 1) ? 16'd479 + 16'($urandom_range(0, 2)) : 16'd639 + 16'($urandom_range(0, 2));
        default: cur_w[i] = 16'($urandom_range(0, (i % 2 == 1) ? 479 : 639));
      endcase
    end
  endtask

  initial begin
    reset = 1'b0;
    opcode_received = 1'b0;
    word_in = '0;
    word_valid = 1'b0;
    next_triangle = 1'b0;
    for (int i = 0; i < 6; i++) exp_coord[i] = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rdy", word_ready, 0);
    check("rst_dr", data_ready, 0);
    check_coords("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // single triangle
    start_list(1);
    set_words(10, 20, 30, 40, 50, 60);
    deliver(0, 0);
    finish_list();

    // clamping
    start_list(1);
    set_words(700, 500, 639, 479, 0, 65535);
    deliver(0, 0);
    finish_list();

    // asynchronous reset in the middle of a fetch
    start_list(1);
    @(negedge clk) next_triangle = 1'b1;
    @(negedge clk) next_triangle = 1'b0;
    word_valid = 1'b1;
    word_in = 16'd5;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    word_valid = 1'b0;
    for (int i = 0; i < 6; i++) exp_coord[i] = '0;
    check("arst_busy", busy, 0);
    check("arst_dr", data_ready, 0);
    check("arst_done", triangle_done, 0);
    check_coords("arst");
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", word_ready, 0);
    check("post_rst_busy", busy, 0);

    // zero count
    start_list(0);

    // stalls, ignored pokes, two triangles
    start_list(2);
    set_words(1, 2, 3, 4, 5, 6);
    deliver(1, 1);
    set_words(600, 400, 800, 900, 7, 8);
    deliver(1, 0);
    finish_list();

    // randomized lists
    for (int l = 0; l < 25; l++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
      start_list(16'(n));
      if (n != 0) begin
        for (int t = 0; t < n; t++) begin
          rand_words();
          deliver(int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0);
        end
        finish_list();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
